pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline sequencer for the EX stage and the front end. It detects load-use hazards and inserts a single bubble into EX. It sequences a fixed-length squash window after an EX redirect, and it freezes the pipeline while MEM reports a multi-cycle access, with a watchdog on that wait. It sits beside `EX_Stage` and drives its `stallStart` input plus the IF/ID hold and squash controls.

## Interface
- `rsWidth`, 5, register-index width
- `opcodeWidth`, 7, opcode width
- `flushCycles`, 2, squash window length in cycles after a redirect; must be ≥1
- `memTimeout`, 64, maximum consecutive `memBusy` cycles before error; must be ≥1
- `clk`  in  1  pipeline clock; all state changes on the rising edge
- `rstN`  in  1  reset; asynchronous, active-low
- `idRs1`, `idRs2`  in  rsWidth  source registers of the instruction in ID
- `idUsesRs1`, `idUsesRs2`  in  1  the ID instruction actually reads that source
- `exOpcode`  in  opcodeWidth  opcode currently presented to EX
- `exRd`  in  rsWidth  destination of the instruction in EX
- `exFlush`  in  1  redirect request (`flushOut` from EX)
- `memBusy`  in  1  MEM access in progress; pipeline must freeze
- `holdFrontEnd`  out  1  IF and ID registers keep their value
- `holdEx`  out  1  EX output registers keep their value
- `stallStart`  out  1  EX captures a bubble (rd=0, noMEM=1)
- `squash`  out  1  IF/ID contents invalid; front end discards them
- `memError`  out  1  sticky watchdog flag
- `stallCycles`  out  32  performance counter (see Configuration)
- `flushCount`  out  32  performance counter (see Configuration)

## Operation
- States: RUN, FLUSH, MEMWAIT. `flushCnt` is `$clog2(flushCycles+1)` bits wide. `memCnt` is `$clog2(memTimeout+1)` bits wide.
- Priority, highest first: `memBusy`, then `exFlush`, then load-use.
- **memBusy = 1, any state:**
  - `holdFrontEnd`, `holdEx` = 1; `stallStart` = 0.
  - `flushCnt` is frozen.
  - `squash` keeps its FLUSH value.
  - From RUN, go to MEMWAIT.
  - `memCnt` increments, saturating at `memTimeout`. When it reaches `memTimeout`, `memError` is set and stays set until reset.
- **MEMWAIT with memBusy = 0:**
  - Return to the saved state: RUN, or FLUSH with the frozen `flushCnt`.
  - `memCnt` clears.
  - `exFlush` is evaluated in this same cycle.
- **RUN, exFlush = 1, memBusy = 0:**
  - `squash` = 1 combinationally and `stallStart` = 1.
  - Next state FLUSH with `flushCnt` = `flushCycles` − 1.
  - If `flushCycles` = 1, stay in RUN.
- **FLUSH:**
  - `squash` = 1 and `stallStart` = 1.
  - `exFlush` is ignored, because it comes from a wrong-path instruction.
  - `flushCnt` decrements; go to RUN when it is 0.
- **Load-use (RUN only, no memBusy, no exFlush):**
  - Condition: `exOpcode` = LOAD (0000011), `exRd` ≠ 0, and (`idUsesRs1` && `idRs1` = `exRd`) or (`idUsesRs2` && `idRs2` = `exRd`).
  - Response: `stallStart` = 1 and `holdFrontEnd` = 1 for exactly that cycle. No state change; the bubble clears the hazard on the next cycle.
- `rd` = x0 never creates a hazard.

## Timing
- All outputs are combinational from state and inputs (Mealy), so they are valid in the same cycle as the inputs.
- Latency: load-use costs 1 bubble; a redirect costs `flushCycles` squashed cycles, plus any `memBusy` cycles that overlap them.
- `memBusy` asserted for N cycles freezes the pipeline for exactly N cycles.
- While `rstN` = 0:
  - State is RUN; `flushCnt` and `memCnt` are 0.
  - `memError` = 0; both counters are 0.
  - All control outputs are forced to 0.
- Reset asserted mid-FLUSH or mid-MEMWAIT aborts the sequence immediately. After release, operation starts in RUN.
- `memError` does not alter sequencing; it is reporting only.

## Configuration
- Macro: `PIPE_CTRL_PERF_EN`.
- Defined:
  - `stallCycles` increments on every cycle with `holdFrontEnd` or `stallStart` = 1.
  - `flushCount` increments on every accepted redirect, i.e. each transition into the squash window.
  - Both wrap at 2^32.
- Undefined: both ports are tied to constant 0, and no counter registers are synthesized.

## Structure
- Package `pipe_ctrl_pkg`:
  - State enum `pipe_state_t` {RUN, FLUSH, MEMWAIT}.
  - Opcode constants OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, shared with the EX stage.
- Sub-module `load_use_detect`: purely combinational comparator producing the hazard bit. Instantiated once.
- The FSM, counters and output decode live in `pipe_ctrl`.

## Test plan
- **Load-use:** `exOpcode` = 0000011, `exRd` = 5, `idRs2` = 5, `idUsesRs2` = 1 → `stallStart` = `holdFrontEnd` = 1 for one cycle, then 0 when EX shows a bubble; same stimulus with `exRd` = 0 → no stall.
- **Redirect:** `exFlush` = 1 for 1 cycle with `flushCycles` = 2 → `squash` = 1 for 2 cycles; a second `exFlush` during FLUSH → ignored, state returns to RUN after 2 cycles.
- **Memory wait:** `memBusy` high 3 cycles starting at FLUSH cycle 1 → `holdEx` = 1 for 3 cycles, `squash` held, FLUSH finishes its remaining cycle after `memBusy` drops.
- **Watchdog:** `memTimeout` = 4, `memBusy` high 6 cycles → `memError` rises on the 4th busy cycle and stays 1 after `memBusy` falls, until `rstN` pulses low.
- **Reset mid-sequence:** `rstN` low during FLUSH → all outputs 0 immediately; after release, a load-use stimulus behaves as in the first scenario.
- **Counters:** with `PIPE_CTRL_PERF_EN`, one load-use plus one 2-cycle redirect → `stallCycles` = 3, `flushCount` = 1; without the macro → both 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: sequencer state encoding and opcode constants shared with the EX stage
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        MEMWAIT
    } pipe_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading the destination of a load sitting in EX
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int rsWidth     = 5,
    parameter int opcodeWidth = 7
) (
    input  logic [rsWidth-1:0]     idRs1,
    input  logic [rsWidth-1:0]     idRs2,
    input  logic                   idUsesRs1,
    input  logic                   idUsesRs2,
    input  logic [opcodeWidth-1:0] exOpcode,
    input  logic [rsWidth-1:0]     exRd,
    output logic                   hazard
);

    // x0 is never a real producer, so it cannot create a hazard
    assign hazard = (exOpcode == opcodeWidth'(OP_LOAD)) && (exRd != '0) &&
                    ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: load-use bubble, redirect squash window and memBusy freeze with watchdog
// Optional PIPE_CTRL_PERF_EN adds the stallCycles / flushCount performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int rsWidth     = 5,
    parameter int opcodeWidth = 7,
    parameter int flushCycles = 2,
    parameter int memTimeout  = 64
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic [rsWidth-1:0]     idRs1,
    input  logic [rsWidth-1:0]     idRs2,
    input  logic                   idUsesRs1,
    input  logic                   idUsesRs2,
    input  logic [opcodeWidth-1:0] exOpcode,
    input  logic [rsWidth-1:0]     exRd,
    input  logic                   exFlush,
    input  logic                   memBusy,
    output logic                   holdFrontEnd,
    output logic                   holdEx,
    output logic                   stallStart,
    output logic                   squash,
    output logic                   memError,
    output logic [31:0]            stallCycles,
    output logic [31:0]            flushCount
);

    localparam int FW = $clog2(flushCycles + 1);
    localparam int MW = $clog2(memTimeout + 1);

    pipe_state_t   state;
    logic [FW-1:0] flush_cnt;
    logic [MW-1:0] mem_cnt;
    logic          err_sticky;
    logic          hazard;
    logic          in_flush;
    logic          err_now;

    load_use_detect #(
        .rsWidth    (rsWidth),
        .opcodeWidth(opcodeWidth)
    ) u_detect (
        .idRs1    (idRs1),
        .idRs2    (idRs2),
        .idUsesRs1(idUsesRs1),
        .idUsesRs2(idUsesRs2),
        .exOpcode (exOpcode),
        .exRd     (exRd),
        .hazard   (hazard)
    );

    // Mealy decode; MEMWAIT without memBusy behaves exactly like RUN, and reset forces all controls low
    always_comb begin
        in_flush     = state == FLUSH;
        err_now      = memBusy && mem_cnt == MW'(memTimeout - 1);
        holdEx       = rstN && memBusy;
        holdFrontEnd = rstN && (memBusy || (!in_flush && !exFlush && hazard));
        stallStart   = rstN && !memBusy && (in_flush || exFlush || hazard);
        squash       = rstN && (in_flush || (!memBusy && exFlush));
        memError     = rstN && (err_sticky || err_now);
    end

    // Sequencer: memBusy freezes everything, FLUSH ignores wrong-path redirects, RUN accepts them
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= RUN;
            flush_cnt  <= '0;
            mem_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (err_now) err_sticky <= 1'b1;
            mem_cnt <= !memBusy ? '0 : (mem_cnt == MW'(memTimeout)) ? mem_cnt : mem_cnt + 1'b1;
            if (memBusy) begin
                if (state == RUN) state <= MEMWAIT;
            end else if (in_flush) begin
                flush_cnt <= flush_cnt - 1'b1;
                if (flush_cnt <= FW'(1)) state <= RUN;
            end else if (exFlush && flushCycles > 1) begin
                state     <= FLUSH;
                flush_cnt <= FW'(flushCycles - 1);
            end else begin
                state <= RUN;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Count stalled cycles and accepted redirects (each opens one squash window)
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (holdFrontEnd || stallStart) stallCycles <= stallCycles + 32'd1;
            if (!memBusy && !in_flush && exFlush) flushCount <= flushCount + 32'd1;
        end
    end
`else
    assign stallCycles = '0;
    assign flushCount  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic against a cycle-level behavioural model
module tb_pipe_ctrl;

    localparam int FC = 2;
    localparam int MT = 4;
    localparam logic [6:0] LOAD = 7'b0000011;

    logic        clk = 1'b0;
    logic        rstN;
    logic [4:0]  idRs1, idRs2, exRd;
    logic        idUsesRs1, idUsesRs2, exFlush, memBusy;
    logic [6:0]  exOpcode;
    logic        holdFrontEnd, holdEx, stallStart, squash, memError;
    logic [31:0] stallCycles, flushCount;

    int checks   = 0;
    int failures = 0;

    // model: squash cycles still owed, current busy run length, sticky error, perf tallies
    int pending, busy_run, n_stall, n_flush;
    bit err;

    pipe_ctrl #(
        .rsWidth    (5),
        .opcodeWidth(7),
        .flushCycles(FC),
        .memTimeout (MT)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .idRs1       (idRs1),
        .idRs2       (idRs2),
        .idUsesRs1   (idUsesRs1),
        .idUsesRs2   (idUsesRs2),
        .exOpcode    (exOpcode),
        .exRd        (exRd),
        .exFlush     (exFlush),
        .memBusy     (memBusy),
        .holdFrontEnd(holdFrontEnd),
        .holdEx      (holdEx),
        .stallStart  (stallStart),
        .squash      (squash),
        .memError    (memError),
        .stallCycles (stallCycles),
        .flushCount  (flushCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int perf(input int v);
`ifdef PIPE_CTRL_PERF_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                        input logic [6:0] op, input logic [4:0] rd, input logic fl, input logic mb);
        bit haz, e_hfe, e_hex, e_ss, e_sq, e_err;
        @(negedge clk);
        idRs1 = r1; idRs2 = r2; idUsesRs1 = u1; idUsesRs2 = u2;
        exOpcode = op; exRd = rd; exFlush = fl; memBusy = mb;
        #1;
        haz = op == LOAD && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
        e_hfe = 0; e_hex = 0; e_ss = 0; e_sq = 0;
        e_err = err || (mb && busy_run + 1 >= MT);
        if (mb) begin
            e_hfe = 1; e_hex = 1; e_sq = pending > 0;
        end else if (pending > 0 || fl) begin
            e_ss = 1; e_sq = 1;
        end else if (haz) begin
            e_ss = 1; e_hfe = 1;
        end
        check("holdFrontEnd", 32'(holdFrontEnd), 32'(e_hfe));
        check("holdEx", 32'(holdEx), 32'(e_hex));
        check("stallStart", 32'(stallStart), 32'(e_ss));
        check("squash", 32'(squash), 32'(e_sq));
        check("memError", 32'(memError), 32'(e_err));
        check("stallCycles", stallCycles, 32'(perf(n_stall)));
        check("flushCount", flushCount, 32'(perf(n_flush)));
        err = e_err;
        if (e_hfe || e_ss) n_stall++;
        if (mb) busy_run++;
        else begin
            busy_run = 0;
            if (pending > 0) pending--;
            else if (fl) begin
                pending = FC - 1;
                n_flush++;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 7'h13, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstN = 1'b0;
        exOpcode = LOAD; exRd = 5; idRs2 = 5; idUsesRs2 = 1; exFlush = 1; memBusy = 1;
        #1;
        check("rst_holdFrontEnd", 32'(holdFrontEnd), 0);
        check("rst_holdEx", 32'(holdEx), 0);
        check("rst_stallStart", 32'(stallStart), 0);
        check("rst_squash", 32'(squash), 0);
        check("rst_memError", 32'(memError), 0);
        check("rst_stallCycles", stallCycles, 0);
        check("rst_flushCount", flushCount, 0);
        pending = 0; busy_run = 0; n_stall = 0; n_flush = 0; err = 0;
        @(negedge clk);
        exFlush = 0; memBusy = 0; idUsesRs2 = 0;
        rstN = 1'b1;
    endtask

    initial begin
        rstN = 1'b0;
        idRs1 = 0; idRs2 = 0; idUsesRs1 = 0; idUsesRs2 = 0;
        exOpcode = 0; exRd = 0; exFlush = 0; memBusy = 0;
        do_reset();

        // load-use bubble, then a bubble in EX, then rd = x0
        step(0, 5, 0, 1, LOAD, 5, 0, 0);
        check("lu_stall", 32'(stallStart), 1);
        check("lu_hold", 32'(holdFrontEnd), 1);
        step(0, 5, 0, 1, 7'h13, 0, 0, 0);
        check("lu_bubble", 32'(stallStart), 0);
        step(0, 5, 0, 1, LOAD, 0, 0, 0);
        check("lu_x0", 32'(stallStart), 0);

        // redirect with a wrong-path redirect inside the window
        step(0, 0, 0, 0, 7'h13, 0, 1, 0);
        check("rd_sq0", 32'(squash), 1);
        step(0, 0, 0, 0, 7'h13, 0, 1, 0);
        check("rd_sq1", 32'(squash), 1);
        idle();
        check("rd_done", 32'(squash), 0);

        // memBusy overlapping the squash window
        step(0, 0, 0, 0, 7'h13, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 7'h13, 0, 0, 1);
            check("mw_holdEx", 32'(holdEx), 1);
            check("mw_squash", 32'(squash), 1);
        end
        idle();
        check("mw_tail", 32'(squash), 1);
        idle();
        check("mw_end", 32'(squash), 0);

        // watchdog
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 0, 0, 7'h13, 0, 0, 1);
            check("wd_flag", 32'(memError), 32'(i >= MT));
        end
        idle();
        check("wd_sticky", 32'(memError), 1);
        do_reset();
        idle();
        check("wd_cleared", 32'(memError), 0);

        // reset mid-FLUSH, then load-use works normally
        step(0, 0, 0, 0, 7'h13, 0, 1, 0);
        do_reset();
        step(0, 5, 0, 1, LOAD, 5, 0, 0);
        check("rst_lu", 32'(stallStart), 1);
        idle();
        do_reset();

        // counters: one load-use plus one 2-cycle redirect
        step(0, 5, 0, 1, LOAD, 5, 0, 0);
        step(0, 0, 0, 0, 7'h13, 0, 1, 0);
        idle();
        idle();
        check("cnt_stall", stallCycles, 32'(perf(3)));
        check("cnt_flush", flushCount, 32'(perf(1)));

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 1) == 1) ? LOAD : 7'($urandom),
                 5'($urandom_range(0, 3)),
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 6) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
